// File: rtl/sd_bus_arb.sv
// Arbiter for the shared SPI-mode SD bus: initialisation lock-out, read/write round-robin,
// enforced idle gap between grants and a watchdog that revokes overrunning read/write grants.
module sd_bus_arb #(
  parameter int TIMEOUT  = 65535,
  parameter int IDLE_GAP = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_req,
  input  logic init_done,
  output logic init_gnt,
  input  logic rd_req,
  input  logic wr_req,
  input  logic rd_done,
  input  logic wr_done,
  output logic rd_gnt,
  output logic wr_gnt,
  input  logic init_cs_n,
  input  logic init_sclk,
  input  logic init_mosi,
  input  logic rd_cs_n,
  input  logic rd_sclk,
  input  logic rd_mosi,
  input  logic wr_cs_n,
  input  logic wr_sclk,
  input  logic wr_mosi,
  output logic sd_cs_n,
  output logic sd_clk,
  output logic sd_mosi,
  output logic init_ok,
  output logic busy,
  output logic timeout_err
);

  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam int GAP_W = $clog2(IDLE_GAP) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR, S_GAP} state_e;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              init_ok_q, init_ok_d;
  logic              last_rd_q, last_rd_d;
  logic              init_pend_q, init_pend_d;
  logic              to_q, to_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      wd_q        <= '0;
      gap_q       <= '0;
      init_ok_q   <= 1'b0;
      last_rd_q   <= 1'b0;
      init_pend_q <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      init_ok_q   <= init_ok_d;
      last_rd_q   <= last_rd_d;
      init_pend_q <= init_pend_d;
      to_q        <= to_d;
    end
  end

  // Counters fall back to zero whenever their state is not active, so every grant or gap starts clean.
  always_comb begin
    state_d     = state_q;
    wd_d        = '0;
    gap_d       = '0;
    init_ok_d   = init_ok_q;
    last_rd_d   = last_rd_q;
    init_pend_d = init_pend_q | init_req;
    to_d        = 1'b0;
    case (state_q)
      S_INIT: begin
        init_pend_d = 1'b0;
        if (init_done) begin
          init_ok_d = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_IDLE: begin
        if (init_req || init_pend_q) begin
          init_ok_d   = 1'b0;
          init_pend_d = 1'b0;
          state_d     = S_INIT;
        end else if (rd_req && (!wr_req || !last_rd_q)) begin
          state_d = S_RD;
        end else if (wr_req) begin
          state_d = S_WR;
        end
      end
      S_RD: begin
        if (rd_done) begin
          last_rd_d = 1'b1;
          state_d   = S_GAP;
        end else if (wd_q == WD_LAST) begin
          to_d      = 1'b1;
          last_rd_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_WR: begin
        if (wr_done) begin
          last_rd_d = 1'b0;
          state_d   = S_GAP;
        end else if (wd_q == WD_LAST) begin
          to_d      = 1'b1;
          last_rd_d = 1'b0;
          state_d   = S_GAP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign init_gnt    = (state_q == S_INIT);
  assign rd_gnt      = (state_q == S_RD);
  assign wr_gnt      = (state_q == S_WR);
  assign busy        = (state_q != S_IDLE);
  assign init_ok     = init_ok_q;
  assign timeout_err = to_q;

  // Without an owner the card sees a deselected, quiet bus.
  always_comb begin
    sd_cs_n = 1'b1;
    sd_clk  = 1'b0;
    sd_mosi = 1'b1;
    case (state_q)
      S_INIT: begin
        sd_cs_n = init_cs_n;
        sd_clk  = init_sclk;
        sd_mosi = init_mosi;
      end
      S_RD: begin
        sd_cs_n = rd_cs_n;
        sd_clk  = rd_sclk;
        sd_mosi = rd_mosi;
      end
      S_WR: begin
        sd_cs_n = wr_cs_n;
        sd_clk  = wr_sclk;
        sd_mosi = wr_mosi;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sd_bus_arb.sv
// Scoreboard bench for sd_bus_arb: behavioural engines answer grants, a transaction-level model
// predicts the grant sequence, and a monitor checks each finished grant plus the bus every cycle.
module tb_sd_bus_arb;
  localparam int TIMEOUT  = 16;
  localparam int IDLE_GAP = 8;

  typedef struct {
    int kind;
    int len;
    int to;
    int gap;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_req = 1'b0, init_done = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic rd_done = 1'b0, wrDoneEng = 1'b0, wrDoneSpur = 1'b0;
  logic wr_done;
  logic [2:0] initSpi = 3'b010, rdSpi = 3'b000, wrSpi = 3'b000;
  logic init_gnt, rd_gnt, wr_gnt, sd_cs_n, sd_clk, sd_mosi, init_ok, busy, timeout_err;

  int errors = 0;
  int checks = 0;
  rec_t sbQ[$];
  int initPlan[$], rdPlan[$], wrPlan[$], tmpRd[$], tmpWr[$];
  int initCnt = 0, rdCnt = 0, wrCnt = 0;
  int curKind = 0, curLen = 0, idleCnt = 0, gapBefore = 0;
  bit lastRd = 1'b0;

  assign wr_done = wrDoneEng | wrDoneSpur;

  sd_bus_arb #(.TIMEOUT(TIMEOUT), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_req(init_req), .init_done(init_done), .init_gnt(init_gnt),
    .rd_req(rd_req), .wr_req(wr_req), .rd_done(rd_done), .wr_done(wr_done),
    .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .init_cs_n(initSpi[2]), .init_sclk(initSpi[1]), .init_mosi(initSpi[0]),
    .rd_cs_n(rdSpi[2]), .rd_sclk(rdSpi[1]), .rd_mosi(rdSpi[0]),
    .wr_cs_n(wrSpi[2]), .wr_sclk(wrSpi[1]), .wr_mosi(wrSpi[0]),
    .sd_cs_n(sd_cs_n), .sd_clk(sd_clk), .sd_mosi(sd_mosi),
    .init_ok(init_ok), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    initSpi = 3'($urandom);
    rdSpi   = 3'($urandom);
    wrSpi   = 3'($urandom);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Each engine finishes its planned transaction on the dur-th granted cycle; a grant lost early abandons it.
  always @(negedge clk) begin
    init_done = 1'b0;
    if (!rst_n) initCnt = 0;
    else if (init_gnt && initPlan.size() != 0) begin
      initCnt++;
      if (initCnt == initPlan[0]) begin
        init_done = 1'b1;
        void'(initPlan.pop_front());
        initCnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    rd_done = 1'b0;
    if (!rst_n) rdCnt = 0;
    else if (rd_gnt && rdPlan.size() != 0) begin
      rdCnt++;
      if (rdCnt == rdPlan[0]) begin
        rd_done = 1'b1;
        void'(rdPlan.pop_front());
        rdCnt = 0;
      end
    end else if (rdCnt != 0) begin
      if (rdPlan.size() != 0) void'(rdPlan.pop_front());
      rdCnt = 0;
    end
    rd_req = (rdPlan.size() != 0);
  end

  always @(negedge clk) begin
    wrDoneEng = 1'b0;
    if (!rst_n) wrCnt = 0;
    else if (wr_gnt && wrPlan.size() != 0) begin
      wrCnt++;
      if (wrCnt == wrPlan[0]) begin
        wrDoneEng = 1'b1;
        void'(wrPlan.pop_front());
        wrCnt = 0;
      end
    end else if (wrCnt != 0) begin
      if (wrPlan.size() != 0) void'(wrPlan.pop_front());
      wrCnt = 0;
    end
    wr_req = (wrPlan.size() != 0);
  end

  task automatic endGrant();
    rec_t e;
    if (sbQ.size() == 0) begin
      checkOutput("unexpected_grant", curKind, 0);
      return;
    end
    e = sbQ.pop_front();
    checkOutput("grant_kind", curKind, e.kind);
    checkOutput("grant_len", curLen, e.len);
    checkOutput("grant_timeout_err", timeout_err, e.to);
    if (e.gap >= 0) checkOutput("grant_gap", gapBefore, e.gap);
  endtask

  // Kinds: 0 none, 1 init, 2 read, 3 write.
  always @(negedge clk) begin
    int gk;
    logic [2:0] expBus;
    if (!rst_n) begin
      curKind = 0;
      curLen  = 0;
      idleCnt = 0;
    end else begin
      gk = init_gnt ? 1 : rd_gnt ? 2 : wr_gnt ? 3 : 0;
      checkOutput("gnt_onehot", ((int'(init_gnt) + int'(rd_gnt) + int'(wr_gnt)) <= 1), 1);
      if (curKind != 0 && gk != curKind) endGrant();
      else checkOutput("timeout_err_quiet", timeout_err, 0);
      if (gk == 0) idleCnt = (curKind != 0) ? 1 : idleCnt + 1;
      else if (gk != curKind) begin
        gapBefore = idleCnt;
        curLen    = 1;
      end else curLen++;
      curKind = gk;
      case (gk)
        1: expBus = initSpi;
        2: expBus = rdSpi;
        3: expBus = wrSpi;
        default: expBus = 3'b101;
      endcase
      checkOutput("sd_bus", {sd_cs_n, sd_clk, sd_mosi}, expBus);
      checkOutput("init_ok", init_ok, !init_gnt);
      checkOutput("busy", busy, (gk != 0 || idleCnt <= IDLE_GAP));
    end
  end

  task automatic pushExp(input int kind, input int dur, input int gap);
    rec_t e;
    e.kind = kind;
    e.len  = (kind != 1 && dur > TIMEOUT) ? TIMEOUT : dur;
    e.to   = (kind != 1 && dur > TIMEOUT) ? 1 : 0;
    e.gap  = gap;
    sbQ.push_back(e);
  endtask

  // Issues tmpRd/tmpWr together and predicts the round-robin service order at transaction level.
  task automatic applyStimulus();
    int r[$];
    int w[$];
    int gap;
    bit pickRd;
    r = tmpRd;
    w = tmpWr;
    gap = -1;
    @(posedge clk); #1;
    foreach (tmpRd[i]) rdPlan.push_back(tmpRd[i]);
    foreach (tmpWr[i]) wrPlan.push_back(tmpWr[i]);
    while (r.size() + w.size() != 0) begin
      pickRd = (r.size() != 0) && (w.size() == 0 || !lastRd);
      if (pickRd) pushExp(2, r.pop_front(), gap);
      else pushExp(3, w.pop_front(), gap);
      lastRd = pickRd;
      gap = IDLE_GAP + 1;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", sbQ.size(), 0);
    sbQ.delete();
    repeat (IDLE_GAP + 3) @(negedge clk);
  endtask

  task automatic waitGnt(input int kind, input bit level);
    int n = 0;
    while (((kind == 2 ? rd_gnt : wr_gnt) != level) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_grant", (kind == 2 ? rd_gnt : wr_gnt), level);
  endtask

  task automatic pulseInit(input int dur);
    @(posedge clk); #1;
    initPlan.push_back(dur);
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  initial begin
    #1;
    checkOutput("rst_init_gnt", init_gnt, 1);
    checkOutput("rst_rd_gnt", rd_gnt, 0);
    checkOutput("rst_wr_gnt", wr_gnt, 0);
    checkOutput("rst_init_ok", init_ok, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_sd_bus", {sd_cs_n, sd_clk, sd_mosi}, initSpi);
    initPlan.push_back(5);
    rdPlan.push_back(3);
    pushExp(1, 5, -1);
    pushExp(2, 3, IDLE_GAP + 1);
    lastRd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    waitDrain();

    tmpRd = '{12, 12}; tmpWr = '{12, 12};
    applyStimulus(); waitDrain();
    tmpRd = '{20}; tmpWr = '{16};
    applyStimulus(); waitDrain();
    tmpRd = '{17, 1}; tmpWr = '{15};
    applyStimulus(); waitDrain();

    rdPlan.push_back(10);
    pushExp(2, 10, -1);
    lastRd = 1'b1;
    waitGnt(2, 1'b1);
    @(posedge clk); #1 wrDoneSpur = 1'b1;
    @(posedge clk); #1 wrDoneSpur = 1'b0;
    waitDrain();

    // init request raised mid-write, with a read queued behind it.
    @(posedge clk); #1;
    wrPlan.push_back(10);
    pushExp(3, 10, -1);
    waitGnt(3, 1'b1);
    @(posedge clk); #1;
    rdPlan.push_back(4);
    pushExp(1, 6, IDLE_GAP + 1);
    pushExp(2, 4, IDLE_GAP + 1);
    lastRd = 1'b1;
    pulseInit(6);
    waitDrain();

    // init request raised during the gap, with a write queued behind it.
    @(posedge clk); #1;
    rdPlan.push_back(3);
    pushExp(2, 3, -1);
    waitGnt(2, 1'b1);
    waitGnt(2, 1'b0);
    wrPlan.push_back(2);
    pushExp(1, 4, IDLE_GAP + 1);
    pushExp(3, 2, IDLE_GAP + 1);
    lastRd = 1'b0;
    pulseInit(4);
    waitDrain();

    for (int b = 0; b < 8; b++) begin
      tmpRd.delete();
      tmpWr.delete();
      repeat ($urandom_range(0, 3)) tmpRd.push_back($urandom_range(1, 20));
      repeat ($urandom_range(0, 3)) tmpWr.push_back($urandom_range(1, 20));
      applyStimulus();
      waitDrain();
    end

    @(posedge clk); #1;
    rdPlan.push_back(12);
    waitGnt(2, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midrst_rd_gnt", rd_gnt, 0);
    checkOutput("midrst_init_gnt", init_gnt, 1);
    checkOutput("midrst_init_ok", init_ok, 0);
    checkOutput("midrst_busy", busy, 1);
    checkOutput("midrst_sd_bus", {sd_cs_n, sd_clk, sd_mosi}, initSpi);
    sbQ.delete();
    rdPlan.delete();
    wrPlan.delete();
    initPlan.delete();
    initPlan.push_back(3);
    pushExp(1, 3, -1);
    lastRd = 1'b0;
    tmpRd = '{2}; tmpWr = '{2};
    applyStimulus();
    @(posedge clk); #1 rst_n = 1'b1;
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
